ptmch_cnt_multi: RTL and testbench
==================================

# ptmch_cnt_multi

Parametrised multi-channel trigger-pulse event counter for the ptmch register block. Each channel synchronises an asynchronous trigger level into the CLK100M domain, detects the selected edge, and counts into a saturating counter. Channels can be individually enabled and cleared. All channels can be snapshotted coherently in one cycle for register readout.

## Interface
- CH_NUM, 5: number of trigger channels (1..32)
- CNT_W, 32: counter width in bits (8..32)
- SAT_LIMIT, 2**CNT_W-1: saturation value; must be ≤ 2**CNT_W-1 and > 0
- SYNC_STG, 2: synchroniser flop stages per channel (2..4)

- CLK100M  in  1  system clock, rising edge only
- RESET  in  1  reset, synchronous, active-high
- TRG_PLS  in  CH_NUM  asynchronous trigger levels, bit n = channel n
- EDGE_MODE  in  2  edge select for all channels: 0 rise, 1 fall, 2 both, 3 none
- CNT_EN  in  CH_NUM  per-channel count enable (level)
- CLR  in  CH_NUM  per-channel clear, one-cycle pulse
- SNAP  in  1  snapshot request, one-cycle pulse
- CNT_OUT  out  CH_NUM*CNT_W  live counters; channel n at [n*CNT_W +: CNT_W]
- SNAP_OUT  out  CH_NUM*CNT_W  snapshot registers, same packing
- SNAP_VLD  out  1  one-cycle pulse: SNAP_OUT updated
- SAT_FLG  out  CH_NUM  sticky per-channel saturation flag

## Operation
- Reset values: CNT_OUT 0, SNAP_OUT 0, SNAP_VLD 0, SAT_FLG 0. Synchroniser stages and the edge-history flop are 0.
- Arm counter: after RESET deasserts, edge detection is masked for SYNC_STG+1 cycles. A trigger already high at reset release is never counted as a rising edge.
- Per channel, let s = last synchroniser stage and d = s delayed one cycle.
  - rise = s & ~d; fall = ~s & d.
  - ev = selected edge per EDGE_MODE (both = rise|fall; none = 0), ANDed with CNT_EN[n] and armed.
- Counter update priority, per channel per cycle:
  - CLR[n] → counter 0 and SAT_FLG[n] 0. A coincident ev is discarded.
  - else counter == SAT_LIMIT → hold.
  - else ev → counter + 1. If the result equals SAT_LIMIT, set SAT_FLG[n] in the same cycle.
  - else hold.
- Counters never wrap. Arithmetic is unsigned, CNT_W bits.
- SNAP: all CH_NUM counters are copied to SNAP_OUT on the same edge. The values are those before the update of that cycle, so a coincident CLR or ev is not reflected. SNAP_VLD pulses on the cycle after SNAP. SNAP_OUT holds until the next SNAP.
- EDGE_MODE and CNT_EN changes act on the next edge evaluation. No retroactive counting of edges seen while disabled.
- CLR during the arm window clears normally.
- RESET asserted mid-operation returns all state to reset values on the next edge.

## Timing
- Synchroniser latency: TRG_PLS change set up before edge k reaches s after edge k+SYNC_STG-1.
- Count latency: the counter reflects the event after edge k+SYNC_STG, i.e. SYNC_STG+1 clocks.
- Minimum TRG_PLS high and low time: 2 CLK100M periods for guaranteed capture. Shorter pulses may be missed, but are never double-counted.
- Maximum count rate: one per 2 clocks in "both" mode; one per 4 clocks in rise or fall mode.
- CLR: effect visible on CNT_OUT 1 clock after the CLR cycle.
- SNAP: SNAP_OUT and SNAP_VLD both valid 1 clock after the SNAP cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset with TRG_PLS = all-ones, release, then hold high 10 cycles → all CNT_OUT stay 0. Drop and re-raise ch0 (rise mode) → CNT_OUT ch0 = 1 exactly SYNC_STG+1 clocks after the input rise.
- EDGE_MODE sweep on ch2 with 3 full pulses: mode 0 → 3, mode 1 → 3, mode 2 → 6, mode 3 → 0. CNT_EN[2] = 0 during pulses → no increment.
- CNT_W = 8, SAT_LIMIT = 200, 205 pulses on ch1 → CNT_OUT ch1 = 200, SAT_FLG[1] = 1 set on the 200th count. CLR[1] → count 0 and flag 0 the next cycle.
- CLR[3] coincident with a detected edge → ch3 = 0, not 1. SNAP in that same cycle with ch3 = 7 → SNAP_OUT ch3 = 7, SNAP_VLD pulses once.
- All 5 channels toggling at random (≥2-clock pulse widths), SNAP every 37 cycles → SNAP_OUT matches a reference model for every channel at every SNAP_VLD.
- RESET asserted mid-count with ch4 = 50 → next cycle CNT_OUT, SNAP_OUT and SAT_FLG are all 0, and the arm window is re-applied.

Source files
------------

// File: rtl/ptmch_cnt_multi.sv
// ptmch_cnt_multi: multi-channel trigger edge counter. Synchronised trigger
// levels feed per-channel saturating counters with clear and coherent snapshot.
module ptmch_cnt_multi #(
   parameter int               CH_NUM    = 5,
   parameter int               CNT_W     = 32,
   parameter logic [CNT_W-1:0] SAT_LIMIT = {CNT_W{1'b1}},
   parameter int               SYNC_STG  = 2
) (
   input  logic                      CLK100M,
   input  logic                      RESET,
   input  logic [CH_NUM-1:0]         TRG_PLS,
   input  logic [1:0]                EDGE_MODE,
   input  logic [CH_NUM-1:0]         CNT_EN,
   input  logic [CH_NUM-1:0]         CLR,
   input  logic                      SNAP,
   output logic [CH_NUM*CNT_W-1:0]   CNT_OUT,
   output logic [CH_NUM*CNT_W-1:0]   SNAP_OUT,
   output logic                      SNAP_VLD,
   output logic [CH_NUM-1:0]         SAT_FLG
);

   localparam int              ARM_W   = 3;
   localparam logic [ARM_W-1:0] ARM_END = ARM_W'(SYNC_STG + 1);

   logic [SYNC_STG-1:0][CH_NUM-1:0] sync_r;
   logic [CH_NUM-1:0]               dly_r;
   logic [ARM_W-1:0]                arm_cnt_r;
   logic                            armed_s;
   logic [CH_NUM-1:0]               rise_s;
   logic [CH_NUM-1:0]               fall_s;
   logic [CH_NUM-1:0]               ev_s;
   logic [CH_NUM-1:0][CNT_W-1:0]    cnt_r;
   logic [CH_NUM-1:0][CNT_W-1:0]    cnt_nxt_s;
   logic [CH_NUM-1:0]               sat_r;
   logic [CH_NUM-1:0]               sat_nxt_s;
   logic [CH_NUM-1:0][CNT_W-1:0]    snap_r;
   logic                            snap_vld_r;

   // Trigger synchroniser chain plus one edge-history stage per channel
   always_ff @(posedge CLK100M) begin
      if (RESET) begin
         sync_r <= '0;
         dly_r  <= '0;
      end else begin
         sync_r[0] <= TRG_PLS;
         for (int i = 1; i < SYNC_STG; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
         dly_r <= sync_r[SYNC_STG-1];
      end
   end

   // Arm window: edges are masked until the zeroed pipeline has filled with real samples
   always_ff @(posedge CLK100M) begin
      if (RESET) begin
         arm_cnt_r <= '0;
      end else if (!armed_s) begin
         arm_cnt_r <= arm_cnt_r + 3'd1;
      end else begin
         arm_cnt_r <= arm_cnt_r;
      end
   end

   assign armed_s = (arm_cnt_r == ARM_END);

   // Edge selection, gated by per-channel enable and the arm window
   always_comb begin
      rise_s = sync_r[SYNC_STG-1] & ~dly_r;
      fall_s = ~sync_r[SYNC_STG-1] & dly_r;
      case (EDGE_MODE)
         2'd0:    ev_s = rise_s;
         2'd1:    ev_s = fall_s;
         2'd2:    ev_s = rise_s | fall_s;
         default: ev_s = '0;
      endcase
      if (armed_s) begin
         ev_s = ev_s & CNT_EN;
      end else begin
         ev_s = '0;
      end
   end

   // Counter next state: clear beats saturation hold beats increment
   always_comb begin
      cnt_nxt_s = cnt_r;
      sat_nxt_s = sat_r;
      for (int n = 0; n < CH_NUM; n++) begin
         if (CLR[n]) begin
            cnt_nxt_s[n] = '0;
            sat_nxt_s[n] = 1'b0;
         end else if (cnt_r[n] == SAT_LIMIT) begin
            cnt_nxt_s[n] = cnt_r[n];
         end else if (ev_s[n]) begin
            cnt_nxt_s[n] = cnt_r[n] + CNT_W'(1);
            if ((cnt_r[n] + CNT_W'(1)) == SAT_LIMIT) begin
               sat_nxt_s[n] = 1'b1;
            end else begin
               sat_nxt_s[n] = sat_r[n];
            end
         end else begin
            cnt_nxt_s[n] = cnt_r[n];
         end
      end
   end

   // Live counters and sticky saturation flags
   always_ff @(posedge CLK100M) begin
      if (RESET) begin
         cnt_r <= '0;
         sat_r <= '0;
      end else begin
         cnt_r <= cnt_nxt_s;
         sat_r <= sat_nxt_s;
      end
   end

   // Snapshot captures pre-update counter values, so a coincident clear or event is not seen
   always_ff @(posedge CLK100M) begin
      if (RESET) begin
         snap_r     <= '0;
         snap_vld_r <= 1'b0;
      end else begin
         snap_vld_r <= SNAP;
         if (SNAP) begin
            snap_r <= cnt_r;
         end else begin
            snap_r <= snap_r;
         end
      end
   end

   assign CNT_OUT  = cnt_r;
   assign SNAP_OUT = snap_r;
   assign SNAP_VLD = snap_vld_r;
   assign SAT_FLG  = sat_r;

endmodule

// File: tb/tb_ptmch_cnt_multi.sv
// Bench for ptmch_cnt_multi: cycle model plus snapshot scoreboard, directed
// scenarios for arm window, edge modes, saturation, clear/snap and reset.
`timescale 1ns/1ps
module tb_ptmch_cnt_multi;

   localparam int             CH   = 5;
   localparam int             CW   = 8;
   localparam int             STG  = 2;
   localparam logic [CW-1:0]  SATL = 8'd200;
   localparam int             BUS  = CH * CW;

   logic           clk = 1'b0;
   logic           rst;
   logic [CH-1:0]  trg;
   logic [1:0]     mode;
   logic [CH-1:0]  cen;
   logic [CH-1:0]  clr;
   logic           snap;
   logic [BUS-1:0] cnt_out;
   logic [BUS-1:0] snap_out;
   logic           snap_vld;
   logic [CH-1:0]  sat_flg;

   always #5 clk = ~clk;

   ptmch_cnt_multi #(
      .CH_NUM(CH), .CNT_W(CW), .SAT_LIMIT(SATL), .SYNC_STG(STG)
   ) dut (
      .CLK100M(clk), .RESET(rst), .TRG_PLS(trg), .EDGE_MODE(mode),
      .CNT_EN(cen), .CLR(clr), .SNAP(snap),
      .CNT_OUT(cnt_out), .SNAP_OUT(snap_out), .SNAP_VLD(snap_vld), .SAT_FLG(sat_flg)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   // Reference model state
   logic [CH-1:0]  m_sh [STG];
   logic [CH-1:0]  m_dly;
   int             m_arm;
   int             m_cnt [CH];
   logic [CH-1:0]  m_sat;
   logic [BUS-1:0] m_snap;
   logic           m_vld;
   logic [BUS-1:0] sbq [$];

   function automatic logic [BUS-1:0] pack_cnt();
      logic [BUS-1:0] pk;
      pk = '0;
      for (int c = 0; c < CH; c++) pk[c*CW +: CW] = CW'(m_cnt[c]);
      return pk;
   endfunction

   function automatic logic [CW-1:0] ch_of(input logic [BUS-1:0] bus, input int c);
      return bus[c*CW +: CW];
   endfunction

   task automatic model_step();
      logic armed;
      logic s, d, e;
      if (rst) begin
         for (int i = 0; i < STG; i++) m_sh[i] = '0;
         m_dly  = '0;
         m_arm  = 0;
         for (int c = 0; c < CH; c++) m_cnt[c] = 0;
         m_sat  = '0;
         m_snap = '0;
         m_vld  = 1'b0;
         sbq.delete();
      end else begin
         armed = (m_arm > STG);
         if (m_arm <= STG) m_arm++;
         m_vld = snap;
         if (snap) begin
            m_snap = pack_cnt();
            sbq.push_back(m_snap);
         end
         for (int c = 0; c < CH; c++) begin
            s = m_sh[STG-1][c];
            d = m_dly[c];
            case (mode)
               2'd0:    e = s && !d;
               2'd1:    e = !s && d;
               2'd2:    e = (s != d);
               default: e = 1'b0;
            endcase
            e = e && cen[c] && armed;
            if (clr[c]) begin
               m_cnt[c] = 0;
               m_sat[c] = 1'b0;
            end else if (m_cnt[c] != int'(SATL) && e) begin
               m_cnt[c]++;
               if (m_cnt[c] == int'(SATL)) m_sat[c] = 1'b1;
            end
         end
         m_dly = m_sh[STG-1];
         for (int i = STG - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
         m_sh[0] = trg;
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Live comparison each cycle, plus snapshot scoreboard pop on SNAP_VLD
   initial forever begin
      @(negedge clk);
      chk("live_cnt",  64'(cnt_out),  64'(pack_cnt()));
      chk("live_sat",  64'(sat_flg),  64'(m_sat));
      chk("live_snap", 64'(snap_out), 64'(m_snap));
      chk("live_vld",  64'(snap_vld), 64'(m_vld));
      if (snap_vld) begin
         if (sbq.size() == 0) chk("sb_spurious", 64'(sbq.size()), 64'd1);
         else                 chk("sb_snap", 64'(snap_out), 64'(sbq.pop_front()));
      end
   end

   initial begin
      #200us;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int c, input int hi, input int lo);
      trg[c] = 1'b1;
      tick(hi);
      trg[c] = 1'b0;
      tick(lo);
   endtask

   task automatic clr_all();
      clr = '1;
      tick(1);
      clr = '0;
      tick(1);
   endtask

   int hold [CH];
   int n_lat;
   int mode_exp [5] = '{3, 3, 6, 0, 0};

   initial begin
      rst = 1'b1; trg = '1; mode = 2'd0; cen = '1; clr = '0; snap = 1'b0;
      tick(3);
      chk("rst_cnt",  64'(cnt_out),  64'd0);
      chk("rst_snap", 64'(snap_out), 64'd0);
      chk("rst_vld",  64'(snap_vld), 64'd0);
      chk("rst_sat",  64'(sat_flg),  64'd0);

      // Triggers high across reset release must not count
      rst = 1'b0;
      tick(10);
      chk("arm_hi_hold", 64'(cnt_out), 64'd0);
      trg[0] = 1'b0;
      tick(4);
      trg[0] = 1'b1;
      n_lat = 0;
      while (n_lat < 10 && ch_of(cnt_out, 0) != 8'd1) begin
         tick(1);
         n_lat++;
      end
      chk("rise_lat", 64'(n_lat), 64'(STG + 1));
      tick(4);

      // Edge mode sweep on ch2; last pass has CNT_EN[2] low
      for (int m = 0; m < 5; m++) begin
         trg  = '0;
         mode = (m == 4) ? 2'd2 : 2'(m);
         cen  = (m == 4) ? 5'b11011 : 5'b11111;
         tick(6);
         clr_all();
         for (int p = 0; p < 3; p++) pulse(2, 3, 3);
         tick(6);
         chk($sformatf("mode_pass%0d", m), 64'(ch_of(cnt_out, 2)), 64'(mode_exp[m]));
      end

      // Saturation on ch1
      mode = 2'd0; cen = '1; trg = '0;
      tick(4);
      clr_all();
      for (int p = 0; p < 205; p++) pulse(1, 2, 2);
      tick(4);
      chk("sat_cnt", 64'(ch_of(cnt_out, 1)), 64'd200);
      chk("sat_flg", 64'(sat_flg[1]), 64'd1);
      clr[1] = 1'b1;
      tick(1);
      clr[1] = 1'b0;
      chk("clr_cnt", 64'(ch_of(cnt_out, 1)), 64'd0);
      chk("clr_flg", 64'(sat_flg[1]), 64'd0);

      // Clear and snapshot coincident with a detected edge on ch3
      for (int p = 0; p < 7; p++) pulse(3, 2, 2);
      tick(4);
      chk("ch3_pre", 64'(ch_of(cnt_out, 3)), 64'd7);
      trg[3] = 1'b1;
      tick(STG);
      clr[3] = 1'b1;
      snap   = 1'b1;
      tick(1);
      clr[3] = 1'b0;
      snap   = 1'b0;
      chk("clr_edge",    64'(ch_of(cnt_out, 3)),  64'd0);
      chk("snap_ch3",    64'(ch_of(snap_out, 3)), 64'd7);
      chk("snap_vld_hi", 64'(snap_vld), 64'd1);
      tick(1);
      chk("snap_vld_lo", 64'(snap_vld), 64'd0);
      tick(4);
      chk("clr_edge_hold", 64'(ch_of(cnt_out, 3)), 64'd0);
      trg[3] = 1'b0;
      tick(4);

      // Random traffic with periodic snapshots
      clr_all();
      for (int c = 0; c < CH; c++) hold[c] = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         for (int c = 0; c < CH; c++) begin
            if (hold[c] == 0) begin
               trg[c]  = ~trg[c];
               hold[c] = int'($urandom_range(2, 5));
            end
            hold[c]--;
         end
         mode = 2'((cyc / 190) % 4);
         if (cyc % 64 == 0) cen = CH'($urandom);
         snap = (cyc % 37 == 36);
         clr  = ($urandom_range(0, 47) == 0) ? CH'(1 << $urandom_range(0, CH - 1)) : '0;
         tick(1);
      end
      snap = 1'b0; clr = '0; trg = '0;
      tick(8);
      chk("sb_drain", 64'(sbq.size()), 64'd0);

      // Reset mid-count with ch4 at 50
      mode = 2'd0; cen = '1;
      clr_all();
      for (int p = 0; p < 50; p++) pulse(4, 2, 2);
      tick(4);
      chk("ch4_50", 64'(ch_of(cnt_out, 4)), 64'd50);
      snap = 1'b1;
      tick(1);
      snap = 1'b0;
      chk("pre_rst_snap", 64'(ch_of(snap_out, 4)), 64'd50);
      trg = '1;
      rst = 1'b1;
      tick(1);
      chk("rst_mid_cnt",  64'(cnt_out),  64'd0);
      chk("rst_mid_snap", 64'(snap_out), 64'd0);
      chk("rst_mid_sat",  64'(sat_flg),  64'd0);
      rst = 1'b0;
      tick(10);
      chk("rearm_hold", 64'(cnt_out), 64'd0);
      trg[4] = 1'b0;
      tick(4);
      trg[4] = 1'b1;
      tick(STG + 1);
      chk("rearm_rise", 64'(ch_of(cnt_out, 4)), 64'd1);
      tick(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
